// File: rtl/img_sched_pkg.sv
// Shared types for the image-buffer port scheduler: frame states, port-B requester ids,
// read-return tag layout and a saturating-counter helper.
`timescale 1ns/1ps
package img_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PROC = 2'd2,
        SEND = 2'd3
    } sched_state_e;

    // Values double as the arbiter request/grant bit index.
    typedef enum logic {
        REQ_ENG = 1'b0,
        REQ_TX  = 1'b1
    } req_id_e;

    localparam int unsigned NPIX = 32'd16384;

    typedef struct packed {
        logic    valid;
        req_id_e id;
    } rd_tag_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter for BRAM port B. Bit 0 is the engine, bit 1 the sender.
// The turn pointer only advances when both eligible requesters contend.
`timescale 1ns/1ps
module rr_arb2
    import img_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst_in,
    input  logic [1:0] req,
    input  logic [1:0] elig,
    output logic [1:0] gnt
);

    logic [1:0] act_s;
    req_id_e    ptr_r;

    // grant selection from the eligible requests and the turn pointer
    always_comb begin
        act_s = req & elig;
        gnt   = 2'b00;
        case (act_s)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (ptr_r == REQ_ENG) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    // hand the turn to the loser after a contested grant
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            ptr_r <= REQ_ENG;
        end else if (act_s == 2'b11) begin
            ptr_r <= (ptr_r == REQ_ENG) ? REQ_TX : REQ_ENG;
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/img_port_scheduler.sv
// Frame sequencer (LOAD -> PROC -> SEND) and port-B arbiter for the 128x128 image BRAM.
// Optional macro IMG_SCHED_STALL_CNT_EN adds saturating per-requester stall counters.
`timescale 1ns/1ps
module img_port_scheduler
    import img_sched_pkg::*;
#(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_in,
    input  logic              start_i,
    output logic              busy_o,
    input  logic              rx_valid_i,
    input  logic [DATA_W-1:0] rx_data_i,
    output logic [ADDR_W-1:0] a_addr_o,
    output logic              a_we_o,
    output logic [DATA_W-1:0] a_din_o,
    output logic              eng_start_o,
    input  logic              eng_done_i,
    input  logic              eng_req_i,
    input  logic [ADDR_W-1:0] eng_addr_i,
    output logic              eng_gnt_o,
    output logic              eng_rvalid_o,
    output logic              tx_start_o,
    input  logic              tx_busy_i,
    input  logic              tx_req_i,
    input  logic [ADDR_W-1:0] tx_addr_i,
    output logic              tx_gnt_o,
    output logic              tx_rvalid_o,
`ifdef IMG_SCHED_STALL_CNT_EN
    output logic [15:0]       eng_stall_o,
    output logic [15:0]       tx_stall_o,
`endif
    output logic [ADDR_W-1:0] b_addr_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ONE_ADDR  = {{(ADDR_W-1){1'b0}}, 1'b1};

    sched_state_e      state_r;
    logic [ADDR_W-1:0] cnt_r;
    logic              busy_seen_r;
    logic [1:0]        elig_s;
    logic [1:0]        req_s;
    logic [1:0]        gnt_s;
    logic [ADDR_W-1:0] b_addr_hold_r;
    rd_tag_t           tag_r [RD_LAT];

    assign busy_o = (state_r != IDLE);

    // frame sequencing, port-A write registers and the entry pulses
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            state_r     <= IDLE;
            cnt_r       <= {ADDR_W{1'b0}};
            busy_seen_r <= 1'b0;
            a_we_o      <= 1'b0;
            a_addr_o    <= {ADDR_W{1'b0}};
            a_din_o     <= {DATA_W{1'b0}};
            eng_start_o <= 1'b0;
            tx_start_o  <= 1'b0;
        end else begin
            a_we_o      <= 1'b0;
            eng_start_o <= 1'b0;
            tx_start_o  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start_i) begin
                        state_r <= LOAD;
                        cnt_r   <= {ADDR_W{1'b0}};
                    end else begin
                        state_r <= IDLE;
                    end
                end
                LOAD: begin
                    if (rx_valid_i) begin
                        a_we_o   <= 1'b1;
                        a_addr_o <= cnt_r;
                        a_din_o  <= rx_data_i;
                        cnt_r    <= cnt_r + ONE_ADDR;
                        if (cnt_r == LAST_ADDR) begin
                            state_r     <= PROC;
                            eng_start_o <= 1'b1;
                        end else begin
                            state_r <= LOAD;
                        end
                    end else begin
                        state_r <= LOAD;
                    end
                end
                PROC: begin
                    if (eng_done_i) begin
                        state_r     <= SEND;
                        tx_start_o  <= 1'b1;
                        busy_seen_r <= 1'b0;
                    end else begin
                        state_r <= PROC;
                    end
                end
                SEND: begin
                    // the sender must first report busy, then drop it, before the frame ends
                    if (!busy_seen_r) begin
                        busy_seen_r <= tx_busy_i;
                    end else if (!tx_busy_i) begin
                        state_r     <= IDLE;
                        busy_seen_r <= 1'b0;
                    end else begin
                        state_r <= SEND;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // the sender may preview-read during PROC; the engine is confined to PROC
    always_comb begin
        elig_s[REQ_ENG] = (state_r == PROC);
        elig_s[REQ_TX]  = (state_r == PROC) || (state_r == SEND);
        req_s[REQ_ENG]  = eng_req_i;
        req_s[REQ_TX]   = tx_req_i;
    end

    rr_arb2 u_arb (
        .clk    (clk),
        .rst_in (rst_in),
        .req    (req_s),
        .elig   (elig_s),
        .gnt    (gnt_s)
    );

    assign eng_gnt_o = gnt_s[REQ_ENG];
    assign tx_gnt_o  = gnt_s[REQ_TX];

    // port-B address follows the winner and parks on the last issued address
    always_comb begin
        if (gnt_s[REQ_ENG]) begin
            b_addr_o = eng_addr_i;
        end else if (gnt_s[REQ_TX]) begin
            b_addr_o = tx_addr_i;
        end else begin
            b_addr_o = b_addr_hold_r;
        end
    end

    // remember the last port-B address
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            b_addr_hold_r <= {ADDR_W{1'b0}};
        end else begin
            b_addr_hold_r <= b_addr_o;
        end
    end

    // read-return tag pipe; keeps draining after the state leaves PROC
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < RD_LAT; i++) begin
                tag_r[i] <= '{valid: 1'b0, id: REQ_ENG};
            end
        end else begin
            tag_r[0] <= '{valid: |gnt_s, id: req_id_e'(gnt_s[REQ_TX])};
            for (int i = 1; i < RD_LAT; i++) begin
                tag_r[i] <= tag_r[i-1];
            end
        end
    end

    assign eng_rvalid_o = tag_r[RD_LAT-1].valid && (tag_r[RD_LAT-1].id == REQ_ENG);
    assign tx_rvalid_o  = tag_r[RD_LAT-1].valid && (tag_r[RD_LAT-1].id == REQ_TX);

`ifdef IMG_SCHED_STALL_CNT_EN
    // cycles each requester spent asking without being served
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            eng_stall_o <= 16'd0;
            tx_stall_o  <= 16'd0;
        end else if (start_i && (state_r == IDLE)) begin
            eng_stall_o <= 16'd0;
            tx_stall_o  <= 16'd0;
        end else begin
            eng_stall_o <= (eng_req_i && !gnt_s[REQ_ENG]) ? sat_inc16(eng_stall_o) : eng_stall_o;
            tx_stall_o  <= (tx_req_i && !gnt_s[REQ_TX]) ? sat_inc16(tx_stall_o) : tx_stall_o;
        end
    end
`endif

endmodule

// File: tb/tb_img_port_scheduler.sv
// Self-checking bench for img_port_scheduler: randomized traffic against a frame-level
// reference model, plus a few directed literal expectations.
`timescale 1ns/1ps
module tb_img_port_scheduler;
    import img_sched_pkg::*;

    localparam int AW  = 14;
    localparam int DW  = 8;
    localparam int LAT = 2;
    localparam int NP  = NPIX;

    logic          clk = 1'b0;
    logic          rst_in;
    logic          start_i, busy_o, rx_valid_i;
    logic [DW-1:0] rx_data_i, a_din_o;
    logic [AW-1:0] a_addr_o, eng_addr_i, tx_addr_i, b_addr_o;
    logic          a_we_o, eng_start_o, eng_done_i, eng_req_i, eng_gnt_o, eng_rvalid_o;
    logic          tx_start_o, tx_busy_i, tx_req_i, tx_gnt_o, tx_rvalid_o;
`ifdef IMG_SCHED_STALL_CNT_EN
    logic [15:0]   eng_stall_o, tx_stall_o;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    img_port_scheduler #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) dut (
        .clk(clk), .rst_in(rst_in), .start_i(start_i), .busy_o(busy_o),
        .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i),
        .a_addr_o(a_addr_o), .a_we_o(a_we_o), .a_din_o(a_din_o),
        .eng_start_o(eng_start_o), .eng_done_i(eng_done_i), .eng_req_i(eng_req_i),
        .eng_addr_i(eng_addr_i), .eng_gnt_o(eng_gnt_o), .eng_rvalid_o(eng_rvalid_o),
        .tx_start_o(tx_start_o), .tx_busy_i(tx_busy_i), .tx_req_i(tx_req_i),
        .tx_addr_i(tx_addr_i), .tx_gnt_o(tx_gnt_o), .tx_rvalid_o(tx_rvalid_o),
`ifdef IMG_SCHED_STALL_CNT_EN
        .eng_stall_o(eng_stall_o), .tx_stall_o(tx_stall_o),
`endif
        .b_addr_o(b_addr_o)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // phase: 0 idle, 1 loading, 2 processing, 3 sending (busy not yet seen), 4 sending (busy seen)
    int            cyc = 0;
    int            m_phase, m_cnt;
    logic          m_we, m_es, m_ts, m_tx_turn;
    logic [AW-1:0] m_aaddr, m_baddr, ba;
    logic [DW-1:0] m_adin;
    int            q_eng[$], q_tx[$];
    logic          re, rt, ge, gt, erv, trv;

    always @(negedge clk) begin
        cyc++;
        if (!rst_in) begin
            m_phase = 0; m_cnt = 0; m_we = 1'b0; m_es = 1'b0; m_ts = 1'b0; m_tx_turn = 1'b0;
            m_aaddr = '0; m_adin = '0; m_baddr = '0;
            q_eng.delete(); q_tx.delete();
        end
        re  = eng_req_i && (m_phase == 2);
        rt  = tx_req_i && (m_phase >= 2);
        ge  = re && (!rt || !m_tx_turn);
        gt  = rt && (!re || m_tx_turn);
        ba  = ge ? eng_addr_i : (gt ? tx_addr_i : m_baddr);
        erv = (q_eng.size() > 0) && (q_eng[0] == cyc);
        trv = (q_tx.size() > 0) && (q_tx[0] == cyc);

        chk("busy", 32'(busy_o), 32'(m_phase != 0));
        chk("a_we", 32'(a_we_o), 32'(m_we));
        chk("a_addr", 32'(a_addr_o), 32'(m_aaddr));
        chk("a_din", 32'(a_din_o), 32'(m_adin));
        chk("eng_start", 32'(eng_start_o), 32'(m_es));
        chk("tx_start", 32'(tx_start_o), 32'(m_ts));
        chk("eng_gnt", 32'(eng_gnt_o), 32'(ge));
        chk("tx_gnt", 32'(tx_gnt_o), 32'(gt));
        chk("b_addr", 32'(b_addr_o), 32'(ba));
        chk("eng_rvalid", 32'(eng_rvalid_o), 32'(erv));
        chk("tx_rvalid", 32'(tx_rvalid_o), 32'(trv));

        if (rst_in) begin
            if (re && rt) m_tx_turn = !m_tx_turn;
            if (erv) void'(q_eng.pop_front());
            if (trv) void'(q_tx.pop_front());
            if (ge) q_eng.push_back(cyc + LAT);
            if (gt) q_tx.push_back(cyc + LAT);
            m_baddr = ba;
            m_we = 1'b0; m_es = 1'b0; m_ts = 1'b0;
            case (m_phase)
                0: if (start_i) begin m_phase = 1; m_cnt = 0; end
                1: if (rx_valid_i) begin
                       m_we = 1'b1; m_aaddr = AW'(m_cnt); m_adin = rx_data_i; m_cnt++;
                       if (m_cnt == NP) begin m_phase = 2; m_es = 1'b1; m_cnt = 0; end
                   end
                2: if (eng_done_i) begin m_phase = 3; m_ts = 1'b1; end
                3: if (tx_busy_i) m_phase = 4;
                4: if (!tx_busy_i) m_phase = 0;
                default: m_phase = 0;
            endcase
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_port_b();
        eng_req_i  = 1'($urandom);
        tx_req_i   = 1'($urandom);
        eng_addr_i = AW'($urandom);
        tx_addr_i  = AW'($urandom);
    endtask

    task automatic load(input int n);
        for (int i = 0; i < n; i++) begin
            while ($urandom_range(0, 9) == 0) begin
                rx_valid_i = 1'b0;
                rand_port_b();
                tick();
            end
            rx_valid_i = 1'b1;
            rx_data_i  = DW'($urandom);
            rand_port_b();
            tick();
        end
        rx_valid_i = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        rst_in = 1'b0; start_i = 1'b0; rx_valid_i = 1'b0; rx_data_i = '0;
        eng_done_i = 1'b0; eng_req_i = 1'b0; eng_addr_i = '0;
        tx_busy_i = 1'b0; tx_req_i = 1'b0; tx_addr_i = '0;
        repeat (3) tick();
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_b_addr", 32'(b_addr_o), 32'd0);
        rst_in = 1'b1;
        tick();

        // aborted frame: reset lands mid-cycle right after pixel 500 was written
        start_i = 1'b1; tick(); start_i = 1'b0;
        load(500);
        chk("pre_rst_addr", 32'(a_addr_o), 32'd499);
        rst_in = 1'b0;
        #1;
        chk("arst_busy", 32'(busy_o), 32'd0);
        chk("arst_we", 32'(a_we_o), 32'd0);
        chk("arst_addr", 32'(a_addr_o), 32'd0);
        chk("arst_din", 32'(a_din_o), 32'd0);
        chk("arst_rvalid", 32'({eng_rvalid_o, tx_rvalid_o}), 32'd0);
        repeat (2) tick();
        rst_in = 1'b1;
        tick();

        // full frame restarts at address 0
        start_i = 1'b1; tick(); start_i = 1'b0;
        rx_valid_i = 1'b1; rx_data_i = 8'hA5; tick(); rx_valid_i = 1'b0;
        chk("first_we", 32'(a_we_o), 32'd1);
        chk("first_addr", 32'(a_addr_o), 32'd0);
        chk("first_din", 32'(a_din_o), 32'hA5);
        load(NP - 1);
        chk("last_addr", 32'(a_addr_o), 32'h3FFF);
        chk("eng_start_pulse", 32'(eng_start_o), 32'd1);

        // engine alone: granted every cycle, data two cycles later
        tx_req_i = 1'b0; eng_req_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            eng_addr_i = AW'(k * 3);
            #1;
            chk("solo_gnt", 32'(eng_gnt_o), 32'd1);
            chk("solo_rvalid", 32'(eng_rvalid_o), 32'(k >= 2));
            tick();
        end

        // both held: first contest goes to the engine, then alternate
        eng_addr_i = 14'd100; tx_addr_i = 14'd200; tx_req_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("alt_eng_gnt", 32'(eng_gnt_o), 32'(k % 2 == 0));
            chk("alt_tx_gnt", 32'(tx_gnt_o), 32'(k % 2 == 1));
            chk("alt_b_addr", 32'(b_addr_o), (k % 2 == 0) ? 32'd100 : 32'd200);
            tick();
        end

        // random traffic in PROC; stray start_i / rx_valid_i must be ignored
        for (int k = 0; k < 300; k++) begin
            rand_port_b();
            start_i    = ($urandom_range(0, 19) == 0);
            rx_valid_i = 1'($urandom);
            rx_data_i  = DW'($urandom);
            tx_busy_i  = 1'($urandom);
            tick();
        end
        start_i = 1'b0; rx_valid_i = 1'b0; tx_busy_i = 1'b0;
        rand_port_b();
        eng_done_i = 1'b1; tick(); eng_done_i = 1'b0;
        chk("tx_start_pulse", 32'(tx_start_o), 32'd1);
        chk("send_busy", 32'(busy_o), 32'd1);

        rx_valid_i = 1'b1; rx_data_i = 8'h3C; tick(); rx_valid_i = 1'b0;
        chk("send_no_write", 32'(a_we_o), 32'd0);

        for (int k = 0; k < 120; k++) begin
            rand_port_b();
            tx_busy_i  = (k >= 20);
            start_i    = ($urandom_range(0, 19) == 0);
            rx_valid_i = 1'($urandom);
            tick();
        end
        start_i = 1'b0; rx_valid_i = 1'b0; eng_req_i = 1'b0; tx_req_i = 1'b0;
        tx_busy_i = 1'b0;
        for (int i = 0; i < 10 && busy_o; i++) tick();
        chk("back_to_idle", 32'(busy_o), 32'd0);

        eng_req_i = 1'b1; tx_req_i = 1'b1;
        #1;
        chk("idle_eng_gnt", 32'(eng_gnt_o), 32'd0);
        chk("idle_tx_gnt", 32'(tx_gnt_o), 32'd0);
        repeat (4) tick();
        eng_req_i = 1'b0; tx_req_i = 1'b0;
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
